// File: rtl/kf8255_pkg.sv
// Shared KF8255 definitions: register address map plus the bus-master
// state encoding and the latched request record.
package kf8255_pkg;

  localparam logic [1:0] KF_ADDR_PORT_A  = 2'b00;
  localparam logic [1:0] KF_ADDR_PORT_B  = 2'b01;
  localparam logic [1:0] KF_ADDR_PORT_C  = 2'b10;
  localparam logic [1:0] KF_ADDR_CONTROL = 2'b11;

  typedef enum logic [1:0] {
    BM_IDLE   = 2'd0,
    BM_SETUP  = 2'd1,
    BM_STROBE = 2'd2,
    BM_HOLD   = 2'd3
  } bm_state_e;

  typedef struct packed {
    logic       write;
    logic [1:0] address;
    logic [7:0] data;
  } bm_request_t;

  localparam bm_request_t BM_REQUEST_RESET = '{write: 1'b0, address: 2'b00, data: 8'h00};

endpackage

// File: rtl/kf8255_bus_cycle_timer.sv
// Loadable 8-bit down-counter that times one bus phase; it parks at zero
// and reports zero so the FSM knows the phase's last cycle has arrived.
module kf8255_bus_cycle_timer (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load_i,
  input  logic [7:0] load_value_i,
  output logic       zero_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_value_i;
    end else if (count_q != 8'd0) begin
      count_d = count_q - 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == 8'd0);

endmodule

// File: rtl/kf8255_bus_master.sv
// KF8255 bus initiator: turns single valid/ready host requests into 8080-style
// chip-select / strobe cycles with programmable setup, strobe and hold lengths.
module kf8255_bus_master
  import kf8255_pkg::*;
#(
  parameter int SETUP_CYCLES  = 1,
  parameter int STROBE_CYCLES = 2,
  parameter int HOLD_CYCLES   = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       request_valid,
  output logic       request_ready,
  input  logic       request_write,
  input  logic [1:0] request_address,
  input  logic [7:0] request_data,
  output logic       response_valid,
  output logic [7:0] response_data,
  output logic       chip_select_n,
  output logic       read_enable_n,
  output logic       write_enable_n,
  output logic [1:0] address,
  output logic [7:0] data_bus_out,
  output logic       data_bus_out_enable,
  input  logic [7:0] data_bus_in
);

  // The responder samples on the falling edge, so a single-cycle strobe
  // would give it no stable edge to sample on.
  if (SETUP_CYCLES < 1 || SETUP_CYCLES > 255) begin : g_bad_setup
    $error("kf8255_bus_master: SETUP_CYCLES must be within 1..255");
  end
  if (STROBE_CYCLES < 2 || STROBE_CYCLES > 255) begin : g_bad_strobe
    $error("kf8255_bus_master: STROBE_CYCLES must be within 2..255");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("kf8255_bus_master: HOLD_CYCLES must be within 1..255");
  end

  localparam logic [7:0] SETUP_LOAD  = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] STROBE_LOAD = 8'(STROBE_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(HOLD_CYCLES - 1);

  bm_state_e   state_q,          state_d;
  bm_request_t request_q,        request_d;
  logic        chip_select_n_q,  chip_select_n_d;
  logic        read_enable_n_q,  read_enable_n_d;
  logic        write_enable_n_q, write_enable_n_d;
  logic        output_enable_q,  output_enable_d;
  logic        response_valid_q, response_valid_d;
  logic [7:0]  response_data_q,  response_data_d;

  logic       timer_load;
  logic [7:0] timer_load_value;
  logic       timer_zero;

  kf8255_bus_cycle_timer u_timer (
    .clock        (clock),
    .reset_n      (reset_n),
    .load_i       (timer_load),
    .load_value_i (timer_load_value),
    .zero_o       (timer_zero)
  );

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d          = state_q;
    request_d        = request_q;
    chip_select_n_d  = chip_select_n_q;
    read_enable_n_d  = read_enable_n_q;
    write_enable_n_d = write_enable_n_q;
    output_enable_d  = output_enable_q;
    response_valid_d = 1'b0;
    response_data_d  = response_data_q;
    timer_load       = 1'b0;
    timer_load_value = 8'd0;

    unique case (state_q)
      BM_IDLE: begin
        if (request_valid) begin
          state_d          = BM_SETUP;
          request_d        = '{write: request_write, address: request_address, data: request_data};
          chip_select_n_d  = 1'b0;
          output_enable_d  = request_write;
          timer_load       = 1'b1;
          timer_load_value = SETUP_LOAD;
        end
      end

      BM_SETUP: begin
        if (timer_zero) begin
          state_d          = BM_STROBE;
          read_enable_n_d  = request_q.write;
          write_enable_n_d = !request_q.write;
          timer_load       = 1'b1;
          timer_load_value = STROBE_LOAD;
        end
      end

      BM_STROBE: begin
        if (timer_zero) begin
          // Read data is taken on the edge that ends the strobe, while the
          // peripheral is still driving it.
          if (!request_q.write) begin
            response_data_d = data_bus_in;
          end
          state_d          = BM_HOLD;
          read_enable_n_d  = 1'b1;
          write_enable_n_d = 1'b1;
          timer_load       = 1'b1;
          timer_load_value = HOLD_LOAD;
        end
      end

      BM_HOLD: begin
        if (timer_zero) begin
          state_d          = BM_IDLE;
          chip_select_n_d  = 1'b1;
          output_enable_d  = 1'b0;
          response_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = BM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= BM_IDLE;
      request_q        <= BM_REQUEST_RESET;
      chip_select_n_q  <= 1'b1;
      read_enable_n_q  <= 1'b1;
      write_enable_n_q <= 1'b1;
      output_enable_q  <= 1'b0;
      response_valid_q <= 1'b0;
      response_data_q  <= 8'h00;
    end else begin
      state_q          <= state_d;
      request_q        <= request_d;
      chip_select_n_q  <= chip_select_n_d;
      read_enable_n_q  <= read_enable_n_d;
      write_enable_n_q <= write_enable_n_d;
      output_enable_q  <= output_enable_d;
      response_valid_q <= response_valid_d;
      response_data_q  <= response_data_d;
    end
  end

  assign request_ready       = (state_q == BM_IDLE);
  assign response_valid      = response_valid_q;
  assign response_data       = response_data_q;
  assign chip_select_n       = chip_select_n_q;
  assign read_enable_n       = read_enable_n_q;
  assign write_enable_n      = write_enable_n_q;
  assign address             = request_q.address;
  assign data_bus_out        = request_q.data;
  assign data_bus_out_enable = output_enable_q;

endmodule
